// File: rtl/gpio_multi.sv
// Multi-pin GPIO peripheral: per-pin hi-Z/output/input mode, synchronised inputs,
// rising/falling edge detection into a write-1-to-clear interrupt status register.
module gpio_multi #(
  parameter int NUM_IO      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic [NUM_IO-1:0] io_pin_i,
  output logic [NUM_IO-1:0] io_pin_o,
  output logic [NUM_IO-1:0] io_oe_o,
  output logic              irq_o
);

  localparam int CW = 2 * NUM_IO;

  localparam logic [3:0] A_CTRL     = 4'd0;
  localparam logic [3:0] A_DATA     = 4'd1;
  localparam logic [3:0] A_IRQ_EN   = 4'd2;
  localparam logic [3:0] A_IRQ_STAT = 4'd3;
  localparam logic [3:0] A_SET      = 4'd4;
  localparam logic [3:0] A_CLR      = 4'd5;

  // Bus protocol: there is no valid/ready handshake. Every clk edge is a bus
  // cycle; with we_i = 1 the write commits at that edge and data_o echoes
  // data_i, with we_i = 0 data_o captures the addressed register (1-cycle latency).

  logic [CW-1:0]     ctrl_q, ctrl_d;
  logic [NUM_IO-1:0] out_q, out_d;
  logic [NUM_IO-1:0] en_r_q, en_r_d;
  logic [NUM_IO-1:0] en_f_q, en_f_d;
  logic [NUM_IO-1:0] stat_q, stat_d;
  logic [NUM_IO-1:0] prev_q, prev_d;
  logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IO-1:0] sync_d [SYNC_STAGES];
  logic [31:0]       data_q, data_d;

  logic [NUM_IO-1:0] mode_out;
  logic [NUM_IO-1:0] mode_in;
  logic [NUM_IO-1:0] sync;
  logic [NUM_IO-1:0] rise;
  logic [NUM_IO-1:0] fall;
  logic [NUM_IO-1:0] edge_hit;
  logic [NUM_IO-1:0] data_view;
  logic [31:0]       rd_val;
  logic [3:0]        reg_addr;
  logic              unused_addr;

  assign reg_addr    = addr_i[3:0];
  assign unused_addr = &{1'b0, addr_i[31:4]};

  // Reserved mode 11 matches neither decode, so it behaves as hi-Z.
  always_comb begin
    mode_out = '0;
    mode_in  = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      mode_out[i] = (ctrl_q[2*i +: 2] == 2'b01);
      mode_in[i]  = (ctrl_q[2*i +: 2] == 2'b10);
    end
  end

  assign sync      = sync_q[SYNC_STAGES-1];
  assign rise      = sync & ~prev_q;
  assign fall      = ~sync & prev_q;
  assign edge_hit  = mode_in & ((rise & en_r_q) | (fall & en_f_q));
  assign data_view = (mode_in & sync) | (~mode_in & out_q);

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      A_CTRL:     rd_val[CW-1:0] = ctrl_q;
      A_DATA:     rd_val[NUM_IO-1:0] = data_view;
      A_IRQ_EN: begin
        rd_val[NUM_IO-1:0]  = en_r_q;
        rd_val[16 +: NUM_IO] = en_f_q;
      end
      A_IRQ_STAT: rd_val[NUM_IO-1:0] = stat_q;
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    out_d  = out_q;
    en_r_d = en_r_q;
    en_f_d = en_f_q;
    stat_d = stat_q;
    if (we_i) begin
      case (reg_addr)
        A_CTRL:     ctrl_d = data_i[CW-1:0];
        A_DATA:     out_d  = data_i[NUM_IO-1:0];
        A_IRQ_EN: begin
          en_r_d = data_i[NUM_IO-1:0];
          en_f_d = data_i[16 +: NUM_IO];
        end
        A_IRQ_STAT: stat_d = stat_q & ~data_i[NUM_IO-1:0];
        A_SET:      out_d  = out_q | data_i[NUM_IO-1:0];
        A_CLR:      out_d  = out_q & ~data_i[NUM_IO-1:0];
        default:    ;
      endcase
    end
    // New edges are OR-ed in after the clear so a coincident set wins.
    stat_d = stat_d | edge_hit;
    prev_d = sync;
    sync_d[0] = io_pin_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    data_d = we_i ? data_i : rd_val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      out_q  <= '0;
      en_r_q <= '0;
      en_f_q <= '0;
      stat_q <= '0;
      prev_q <= '0;
      data_q <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      ctrl_q <= ctrl_d;
      out_q  <= out_d;
      en_r_q <= en_r_d;
      en_f_q <= en_f_d;
      stat_q <= stat_d;
      prev_q <= prev_d;
      data_q <= data_d;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign data_o   = data_q;
  assign io_pin_o = out_q;
  assign io_oe_o  = mode_out;
  assign irq_o    = |stat_q;

endmodule
